stopwatch_core_multi: RTL and testbench

- Parametrised successor to the fixed 2-digit-second stopwatch control path.
- Generalises the seconds digit count and the clock-to-centisecond prescaler; adds count-down mode with preset load, an explicit run/pause/done FSM, and a lap-time ring buffer with a read handshake.
- Sits between the button inputs and the VGA digit renderer. Replaces the separate 100 Hz clock with a single-clock tick enable.

---
 rtl/stopwatch_core_multi.sv | 231 +++++++++++++++++++++++
 tb/tb_stopwatch_core_multi.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core_multi.sv
// Stopwatch control path: button edge detection, run/pause/done FSM,
// centisecond prescaler, parametrised BCD up/down counter and a lap-time
// ring buffer with a registered pop handshake. Single clock domain; the
// prescaler produces a one-cycle tick enable instead of a divided clock.
module stopwatch_core_multi #(
  parameter int CLK_DIV    = 1000000,
  parameter int SEC_DIGITS = 2,
  parameter int LAP_DEPTH  = 4,
  parameter int LAP_AW     = 2
) (
  input  logic                          clk_100mhz,
  input  logic                          rst_n,
  input  logic                          start_stop,
  input  logic                          lap,
  input  logic                          clear,
  input  logic                          count_down,
  input  logic [4*(SEC_DIGITS+2)-1:0]   preset_bcd,
  output logic [4*(SEC_DIGITS+2)-1:0]   time_bcd,
  output logic                          time_out,
  output logic                          running,
  input  logic                          lap_rd,
  output logic [4*(SEC_DIGITS+2)-1:0]   lap_rd_data,
  output logic                          lap_rd_valid,
  output logic [LAP_AW:0]               lap_count,
  output logic                          lap_overflow
);

  localparam int NDIG = SEC_DIGITS + 2;
  localparam int TW   = 4 * NDIG;
  localparam int PW   = $clog2(CLK_DIV);

  localparam logic [PW-1:0]     P_MAX    = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0]     P_ONE    = PW'(1);
  localparam logic [LAP_AW-1:0] PTR_ONE  = LAP_AW'(1);
  localparam logic [LAP_AW:0]   CNT_ONE  = (LAP_AW + 1)'(1);
  localparam logic [LAP_AW:0]   CNT_FULL = (LAP_AW + 1)'(LAP_DEPTH);

  // Largest value of each digit: tens-of-seconds rolls at 5, all others at 9.
  function automatic logic [3:0] digit_max(input int idx);
    return (idx == 3) ? 4'd5 : 4'd9;
  endfunction

  // Up-count terminal value: every digit at its own maximum (e.g. 59.99).
  function automatic logic [TW-1:0] term_up_value();
    logic [TW-1:0] v;
    v = '0;
    for (int i = 0; i < NDIG; i++) v[4*i +: 4] = digit_max(i);
    return v;
  endfunction

  localparam logic [TW-1:0] TERM_UP = term_up_value();

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_down;
  logic [PW-1:0]     r_presc;
  logic [TW-1:0]     r_time, w_time_nxt;
  logic [2:0]        r_sync1, r_sync2, r_prev;
  logic [2:0]        w_edge;
  logic              w_clr_e, w_ss_e, w_lap_e;
  logic              w_tick, w_at_term, w_load_preset;

  logic [TW-1:0]     r_lap_mem [LAP_DEPTH];
  logic [LAP_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LAP_AW:0]   r_lap_count;
  logic              r_lap_ovf;
  logic [TW-1:0]     r_rd_data;
  logic              r_rd_valid;
  logic              w_push, w_pop, w_full;

  // Two-flop synchroniser plus previous-value register for {clear, start_stop, lap}.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= {clear, start_stop, lap};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Rising edges with priority clear > start_stop > lap.
  assign w_edge  = r_sync2 & ~r_prev;
  assign w_clr_e = w_edge[2];
  assign w_ss_e  = w_edge[1] & ~w_edge[2];
  assign w_lap_e = w_edge[0] & ~w_edge[1] & ~w_edge[2];

  assign w_tick  = (r_state == S_RUN) && (r_presc == P_MAX);

  // Cascaded +1 / -1 across all digits; carry or borrow ripples combinationally.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    logic       w_carry;
    logic [3:0] w_dig;
    w_time_nxt = r_time;
    w_carry    = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      w_dig = r_time[4*i +: 4];
      if (w_carry) begin
        if (!r_down) begin
          if (w_dig == digit_max(i)) begin
            w_time_nxt[4*i +: 4] = 4'd0;
          end else begin
            w_time_nxt[4*i +: 4] = w_dig + 4'd1;
            w_carry              = 1'b0;
          end
        end else begin
          if (w_dig == 4'd0) begin
            w_time_nxt[4*i +: 4] = digit_max(i);
          end else begin
            w_time_nxt[4*i +: 4] = w_dig - 4'd1;
            w_carry              = 1'b0;
          end
        end
      end
    end
  end

  assign w_at_term = r_down ? (w_time_nxt == '0) : (w_time_nxt == TERM_UP);

  // Next-state logic; reaching the terminal value wins over a pause request.
  always_comb begin
    w_state_nxt   = r_state;
    w_load_preset = 1'b0;
    if (w_clr_e) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ss_e) begin
            w_load_preset = count_down;
            w_state_nxt   = (count_down && (preset_bcd == '0)) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_tick && w_at_term) w_state_nxt = S_DONE;
          else if (w_ss_e)         w_state_nxt = S_PAUSE;
        end
        S_PAUSE: begin
          if (w_ss_e) w_state_nxt = S_RUN;
        end
        S_DONE:  w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register and direction latched on the IDLE start edge.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_down  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (!w_clr_e && (r_state == S_IDLE) && w_ss_e) r_down <= count_down;
    end
  end

  // Prescaler runs only in RUN and keeps its partial count while paused.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_clr_e) begin
      r_presc <= '0;
    end else if (r_state == S_RUN) begin
      r_presc <= w_tick ? '0 : r_presc + P_ONE;
    end
  end

  // Time register: cleared, preset-loaded on a down-mode start, stepped on tick.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_time <= '0;
    end else if (w_clr_e) begin
      r_time <= '0;
    end else if (w_load_preset) begin
      r_time <= preset_bcd;
    end else if (w_tick) begin
      r_time <= w_time_nxt;
    end
  end

  assign w_full = (r_lap_count == CNT_FULL);
  assign w_push = w_lap_e && ((r_state == S_RUN) || (r_state == S_PAUSE));
  assign w_pop  = lap_rd && (r_lap_count != '0) && !w_clr_e;

  // Lap storage; a write while full lands on the oldest slot (wr_ptr == rd_ptr).
  // NOTE: the lap memory has no reset; a slot is only ever read after it was written.
  always_ff @(posedge clk_100mhz) begin
    if (w_push) r_lap_mem[r_wr_ptr] <= r_time;
  end

  // Ring-buffer pointers, occupancy, overflow flag and registered pop port.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_lap_count <= '0;
      r_lap_ovf   <= 1'b0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
    end else if (w_clr_e) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_lap_count <= '0;
      r_lap_ovf   <= 1'b0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) r_rd_data <= r_lap_mem[r_rd_ptr];
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop || (w_push && w_full)) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop && !w_full)  r_lap_count <= r_lap_count + CNT_ONE;
      else if (w_pop && !w_push)        r_lap_count <= r_lap_count - CNT_ONE;
      if (w_push && w_full && !w_pop)   r_lap_ovf <= 1'b1;
    end
  end

  assign time_bcd     = r_time;
  assign time_out     = (r_state == S_DONE);
  assign running      = (r_state == S_RUN);
  assign lap_rd_data  = r_rd_data;
  assign lap_rd_valid = r_rd_valid;
  assign lap_count    = r_lap_count;
  assign lap_overflow = r_lap_ovf;

endmodule

// File: tb/tb_stopwatch_core_multi.sv
// Bench for stopwatch_core_multi (CLK_DIV=4, SEC_DIGITS=2, LAP_DEPTH=4).
// A centisecond-integer reference model tracks every clock; directed
// sequences, a down-mode vector table and random stimulus exercise it.
module tb_stopwatch_core_multi;

  localparam int CLK_DIV    = 4;
  localparam int SEC_DIGITS = 2;
  localparam int LAP_DEPTH  = 4;
  localparam int LAP_AW     = 2;
  localparam int TW         = 4 * (SEC_DIGITS + 2);
  localparam int UP_LIMIT   = 5999;

  localparam int ST_IDLE  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_PAUSE = 2;
  localparam int ST_DONE  = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
  logic            count_down = 1'b0, lap_rd = 1'b0;
  logic [TW-1:0]   preset_bcd = '0;
  logic [TW-1:0]   time_bcd, lap_rd_data;
  logic            time_out, running, lap_rd_valid, lap_overflow;
  logic [LAP_AW:0] lap_count;

  always #5 clk = ~clk;

  stopwatch_core_multi #(
    .CLK_DIV(CLK_DIV), .SEC_DIGITS(SEC_DIGITS), .LAP_DEPTH(LAP_DEPTH), .LAP_AW(LAP_AW)
  ) dut (
    .clk_100mhz(clk), .rst_n(rst_n), .start_stop(start_stop), .lap(lap),
    .clear(clear), .count_down(count_down), .preset_bcd(preset_bcd),
    .time_bcd(time_bcd), .time_out(time_out), .running(running),
    .lap_rd(lap_rd), .lap_rd_data(lap_rd_data), .lap_rd_valid(lap_rd_valid),
    .lap_count(lap_count), .lap_overflow(lap_overflow)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] int2bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int bcd2int(input logic [15:0] b);
    return int'(b[3:0]) + 10 * int'(b[7:4]) + 100 * int'(b[11:8]) + 1000 * int'(b[15:12]);
  endfunction

  // Reference model: time held as integer centiseconds, laps in a queue.
  int         m_phase, m_val, m_runclk, m_rd_data;
  bit         m_down, m_ovf, m_rd_valid;
  int         m_q[$];
  logic [2:0] h_ss, h_lap, h_clr;   // [0]=previous edge sample, [1]=two back, [2]=three back

  task automatic model_reset();
    m_phase = ST_IDLE; m_val = 0; m_runclk = 0; m_rd_data = 0;
    m_down = 0; m_ovf = 0; m_rd_valid = 0;
    m_q.delete();
    h_ss = '0; h_lap = '0; h_clr = '0;
  endtask

  task automatic model_step();
    bit ce, se, le, hit_term;
    bit tick;
    ce = h_clr[1] & ~h_clr[2];
    se = h_ss[1] & ~h_ss[2] & ~ce;
    le = h_lap[1] & ~h_lap[2] & ~ce & ~se;
    h_clr = {h_clr[1:0], clear};
    h_ss  = {h_ss[1:0], start_stop};
    h_lap = {h_lap[1:0], lap};
    m_rd_valid = 0;
    if (ce) begin
      m_phase = ST_IDLE; m_val = 0; m_runclk = 0; m_ovf = 0;
      m_q.delete();
    end else begin
      if (lap_rd && m_q.size() > 0) begin
        m_rd_data  = m_q.pop_front();
        m_rd_valid = 1;
      end
      if (le && (m_phase == ST_RUN || m_phase == ST_PAUSE)) begin
        m_q.push_back(m_val);
        if (m_q.size() > LAP_DEPTH) begin
          void'(m_q.pop_front());
          m_ovf = 1;
        end
      end
      case (m_phase)
        ST_IDLE: if (se) begin
          m_down = count_down;
          if (m_down) m_val = bcd2int(preset_bcd);
          m_phase = (m_down && m_val == 0) ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          tick = (m_runclk % CLK_DIV) == (CLK_DIV - 1);
          m_runclk++;
          hit_term = 0;
          if (tick) begin
            m_val    = m_down ? m_val - 1 : m_val + 1;
            hit_term = (m_val == (m_down ? 0 : UP_LIMIT));
          end
          if (hit_term) m_phase = ST_DONE;
          else if (se)  m_phase = ST_PAUSE;
        end
        ST_PAUSE: if (se) m_phase = ST_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic compare_model();
    check($sformatf("model@%0t", $time),
          64'({time_bcd, lap_rd_data, lap_count, lap_rd_valid, lap_overflow, time_out, running}),
          64'({int2bcd(m_val), int2bcd(m_rd_data), 3'(m_q.size()), m_rd_valid, m_ovf,
               m_phase == ST_DONE, m_phase == ST_RUN}));
  endtask

  // One clock: model follows the edge, DUT compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  typedef struct {
    logic        ss;
    logic        clr;
    logic        cd;
    logic [15:0] preset;
    int          ncyc;
    logic [15:0] exp_time;
    logic        exp_to;
    logic        exp_run;
  } step_t;

  step_t tbl[14];
  int    exp_laps[$];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 16'h0003, 3, 16'h0003, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 16'h0003, 4, 16'h0002, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 16'h0003, 4, 16'h0001, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 16'h0003, 4, 16'h0000, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 16'h0003, 8, 16'h0000, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 16'h0003, 3, 16'h0000, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 2, 16'h0000, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 3, 16'h0000, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 3, 16'h0000, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 16'h1000, 3, 16'h1000, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 16'h1000, 4, 16'h0999, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 16'h1000, 4, 16'h0998, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 16'h1000, 3, 16'h0000, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 16'h1000, 2, 16'h0000, 1'b0, 1'b0};

    // Power-on reset
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_time", 64'(time_bcd), 64'(0));
    check("rst_flags", 64'({time_out, running, lap_rd_valid, lap_overflow, lap_count}), 64'(0));

    // Up count, pause and resume with the partial tick preserved
    start_stop = 1'b1; repeat (3) cyc();
    check("start_running", 64'(running), 64'(1));
    start_stop = 1'b0; repeat (400) cyc();
    check("up_100_ticks", 64'(time_bcd), 64'(16'h0100));
    start_stop = 1'b1; repeat (3) cyc();
    check("pause_running", 64'(running), 64'(0));
    start_stop = 1'b0; repeat (40) cyc();
    check("pause_hold", 64'(time_bcd), 64'(16'h0100));
    start_stop = 1'b1; repeat (3) cyc();
    check("resume_running", 64'(running), 64'(1));
    check("resume_time", 64'(time_bcd), 64'(16'h0100));
    start_stop = 1'b0; cyc();
    check("resume_partial_tick", 64'(time_bcd), 64'(16'h0101));

    // Five laps into a four-deep buffer, then drain
    for (int i = 0; i < 5; i++) begin
      lap = 1'b1; cyc();
      lap = 1'b0; cyc();
    end
    repeat (2) cyc();
    check("lap_count_full", 64'(lap_count), 64'(4));
    check("lap_overflow", 64'(lap_overflow), 64'(1));
    exp_laps = m_q;
    for (int i = 0; i < 4; i++) begin
      lap_rd = 1'b1; cyc();
      check($sformatf("lap_rd_valid%0d", i), 64'(lap_rd_valid), 64'(1));
      check($sformatf("lap_rd_data%0d", i), 64'(lap_rd_data), 64'(int2bcd(exp_laps[i])));
      lap_rd = 1'b0; cyc();
      check($sformatf("lap_valid_drop%0d", i), 64'(lap_rd_valid), 64'(0));
    end
    check("lap_count_empty", 64'(lap_count), 64'(0));
    lap_rd = 1'b1; cyc();
    check("lap_rd_empty", 64'(lap_rd_valid), 64'(0));
    lap_rd = 1'b0;

    // clear and start_stop on the same cycle while running
    clear = 1'b1; start_stop = 1'b1; repeat (3) cyc();
    check("clr_ss_time", 64'(time_bcd), 64'(0));
    check("clr_ss_state", 64'({time_out, running, lap_overflow}), 64'(0));
    clear = 1'b0; start_stop = 1'b0; repeat (2) cyc();
    check("clr_ss_idle", 64'(running), 64'(0));

    // Held start_stop toggles exactly once
    start_stop = 1'b1; repeat (100) cyc();
    check("held_once", 64'(running), 64'(1));
    check("held_time", 64'(time_bcd), 64'(16'h0024));
    start_stop = 1'b0; repeat (3) cyc();
    check("held_release", 64'(running), 64'(1));
    clear = 1'b1; repeat (3) cyc();
    clear = 1'b0; cyc();
    check("held_cleared", 64'(time_bcd), 64'(0));

    // Up saturation at 59.99
    start_stop = 1'b1; repeat (3) cyc();
    start_stop = 1'b0;
    begin
      int k;
      k = 0;
      while (time_out !== 1'b1 && k < 26000) begin
        cyc();
        k++;
      end
    end
    check("sat_reached", 64'(time_out), 64'(1));
    check("sat_time", 64'(time_bcd), 64'(16'h5999));
    check("sat_running", 64'(running), 64'(0));
    start_stop = 1'b1; repeat (3) cyc();
    start_stop = 1'b0; lap = 1'b1; repeat (3) cyc();
    lap = 1'b0; repeat (8) cyc();
    check("sat_hold_time", 64'(time_bcd), 64'(16'h5999));
    check("sat_hold_done", 64'(time_out), 64'(1));
    check("sat_no_lap", 64'(lap_count), 64'(0));
    clear = 1'b1; repeat (3) cyc();
    clear = 1'b0; cyc();
    check("sat_cleared", 64'({time_bcd, time_out, running}), 64'(0));

    // Down-mode vector table
    for (int i = 0; i < 14; i++) begin
      start_stop = tbl[i].ss;
      clear      = tbl[i].clr;
      count_down = tbl[i].cd;
      preset_bcd = tbl[i].preset;
      repeat (tbl[i].ncyc) cyc();
      check($sformatf("tbl%0d_time", i), 64'(time_bcd), 64'(tbl[i].exp_time));
      check($sformatf("tbl%0d_done", i), 64'(time_out), 64'(tbl[i].exp_to));
      check($sformatf("tbl%0d_run", i), 64'(running), 64'(tbl[i].exp_run));
    end

    // Asynchronous reset between clock edges while running
    count_down = 1'b0;
    start_stop = 1'b1; repeat (3) cyc();
    start_stop = 1'b0; repeat (10) cyc();
    lap = 1'b1; cyc();
    lap = 1'b0; repeat (3) cyc();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_time", 64'(time_bcd), 64'(0));
    check("arst_flags", 64'({time_out, running, lap_rd_valid, lap_overflow, lap_count}), 64'(0));
    check("arst_rd_data", 64'(lap_rd_data), 64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    check("arst_idle", 64'({time_bcd, running, time_out}), 64'(0));

    // Random stimulus against the model
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 7) == 0)  start_stop = ~start_stop;
      if ($urandom_range(0, 5) == 0)  lap = ~lap;
      if ($urandom_range(0, 59) == 0) clear = ~clear;
      lap_rd = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) count_down = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) preset_bcd = int2bcd(int'($urandom_range(0, 30)));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
